// File: rtl/axi_slave_deserializer.sv
// AXI-stream byte receiver: assembles up to DATA_BYTES stream bytes (first
// byte in the least-significant slot) into one word, then holds it with
// ready=0 until local logic releases it with a one-cycle read strobe.
module axi_slave_deserializer #(
    parameter int unsigned DATA_BYTES = 8,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned LEN_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [BYTE_W-1:0]            data,
    input  logic                         valid,
    input  logic                         last,
    output logic                         ready,
    output logic [DATA_BYTES*BYTE_W-1:0] data_out,
    output logic                         word_valid,
    output logic [LEN_W-1:0]             word_len,
    output logic                         err_nolast,
    input  logic                         re
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(DATA_BYTES - 1);

    state_t                         state, state_next;
    logic [DATA_BYTES*BYTE_W-1:0]   buffer, buffer_next;
    logic [LEN_W-1:0]               byte_cnt, byte_cnt_next;
    logic [LEN_W-1:0]               word_len_next;
    logic                           word_valid_next;
    logic                           err_nolast_next;
    logic                           ready_next;
    logic                           transfer;

    // The buffer is presented directly, so intermediate accepts are visible.
    assign data_out = buffer;
    assign transfer = (state == RECV) && valid && ready;

    // Next-state and datapath update; all outputs default to holding.
    always_comb begin
        state_next      = state;
        buffer_next     = buffer;
        byte_cnt_next   = byte_cnt;
        word_len_next   = word_len;
        word_valid_next = word_valid;
        err_nolast_next = err_nolast;

        case (state)
            IDLE: begin
                state_next = RECV;
            end
            RECV: begin
                if (transfer) begin
                    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                        if (byte_cnt == LEN_W'(i)) begin
                            buffer_next[i*BYTE_W +: BYTE_W] = data;
                        end
                    end
                    byte_cnt_next = byte_cnt + LEN_W'(1);
                    if (last || (byte_cnt == LAST_IDX)) begin
                        state_next      = HOLD;
                        word_valid_next = 1'b1;
                        word_len_next   = byte_cnt + LEN_W'(1);
                        err_nolast_next = ~last;
                    end
                end
            end
            HOLD: begin
                if (re) begin
                    state_next      = RECV;
                    word_valid_next = 1'b0;
                    err_nolast_next = 1'b0;
                    byte_cnt_next   = '0;
                    buffer_next     = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // ready is registered: it reflects the state entered at this edge.
        ready_next = (state_next == RECV);
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            buffer     <= '0;
            byte_cnt   <= '0;
            word_len   <= '0;
            word_valid <= 1'b0;
            err_nolast <= 1'b0;
            ready      <= 1'b0;
        end else begin
            state      <= state_next;
            buffer     <= buffer_next;
            byte_cnt   <= byte_cnt_next;
            word_len   <= word_len_next;
            word_valid <= word_valid_next;
            err_nolast <= err_nolast_next;
            ready      <= ready_next;
        end
    end

endmodule

// File: tb/tb_axi_slave_deserializer.sv
// Directed self-checking bench for axi_slave_deserializer (8 x 8-bit word).
module tb_axi_slave_deserializer;

    logic        clk;
    logic        reset_n;
    logic [7:0]  data;
    logic        valid;
    logic        last;
    logic        ready;
    logic [63:0] data_out;
    logic        word_valid;
    logic [3:0]  word_len;
    logic        err_nolast;
    logic        re;

    int checks;
    int errors;

    axi_slave_deserializer #(
        .DATA_BYTES(8),
        .BYTE_W(8),
        .LEN_W(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .data(data),
        .valid(valid),
        .last(last),
        .ready(ready),
        .data_out(data_out),
        .word_valid(word_valid),
        .word_len(word_len),
        .err_nolast(err_nolast),
        .re(re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle read strobe to release a held word.
    task automatic release_word();
        re = 1'b1;
        step();
        re = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_word_valid got %b exp 0", word_valid); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err_nolast); end
        checks++; if (word_len !== 4'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", word_len); end
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL reset_data got %h exp 0", data_out); end
        step();
        reset_n = 1'b1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b exp 0", ready); end
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL recv_ready got %b exp 1", ready); end
    endtask

    task automatic test_full_word();
        logic [7:0] b [8];
        b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        for (int i = 0; i < 8; i++) begin
            data  = b[i];
            valid = 1'b1;
            last  = (i == 7);
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_ready_%0d got %b exp 1", i, ready); end
            step();
        end
        valid = 1'b0;
        last  = 1'b0;
        checks++; if (data_out !== 64'hF0DEBC9A78563412) begin errors++; $display("FAIL full_data got %h exp F0DEBC9A78563412", data_out); end
        checks++; if (word_len !== 4'd8) begin errors++; $display("FAIL full_len got %0d exp 8", word_len); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", err_nolast); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL full_wv got %b exp 1", word_valid); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_hold_ready got %b exp 0", ready); end
        release_word();
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL full_rel_wv got %b exp 0", word_valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_rel_ready got %b exp 1", ready); end
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL full_rel_data got %h exp 0", data_out); end
        checks++; if (word_len !== 4'd8) begin errors++; $display("FAIL full_rel_len got %0d exp 8", word_len); end
    endtask

    task automatic test_short();
        logic [7:0] b [4];
        b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        for (int i = 0; i < 4; i++) begin
            data  = b[i];
            valid = 1'b1;
            last  = (i == 3);
            step();
            if (i == 1) begin
                checks++; if (data_out !== 64'h000000000000B2A1) begin errors++; $display("FAIL short_partial got %h exp B2A1", data_out); end
                checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL short_partial_wv got %b exp 0", word_valid); end
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        checks++; if (data_out !== 64'h00000000D4C3B2A1) begin errors++; $display("FAIL short_data got %h exp 00000000D4C3B2A1", data_out); end
        checks++; if (word_len !== 4'd4) begin errors++; $display("FAIL short_len got %0d exp 4", word_len); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL short_err got %b exp 0", err_nolast); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL short_wv got %b exp 1", word_valid); end
        release_word();
    endtask

    task automatic test_gaps();
        logic [7:0] b [8];
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 8; i++) begin
            data  = b[i];
            valid = 1'b1;
            last  = (i == 7);
            step();
            if (i == 2) begin
                valid = 1'b0;
                data  = 8'hFF;
                repeat (5) step();
                checks++; if (data_out !== 64'h0000000000332211) begin errors++; $display("FAIL gap_partial got %h exp 332211", data_out); end
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        checks++; if (data_out !== 64'h8877665544332211) begin errors++; $display("FAIL gap_data got %h exp 8877665544332211", data_out); end
        checks++; if (word_len !== 4'd8) begin errors++; $display("FAIL gap_len got %0d exp 8", word_len); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL gap_err got %b exp 0", err_nolast); end
        release_word();
    endtask

    task automatic test_missing_last();
        for (int i = 0; i < 8; i++) begin
            data  = 8'(i + 1);
            valid = 1'b1;
            last  = 1'b0;
            step();
        end
        // Transmitter keeps offering the next packet's byte during the hold.
        data = 8'h99;
        last = 1'b1;
        checks++; if (err_nolast !== 1'b1) begin errors++; $display("FAIL nolast_err got %b exp 1", err_nolast); end
        checks++; if (word_len !== 4'd8) begin errors++; $display("FAIL nolast_len got %0d exp 8", word_len); end
        checks++; if (data_out !== 64'h0807060504030201) begin errors++; $display("FAIL nolast_data got %h exp 0807060504030201", data_out); end
        repeat (3) step();
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL nolast_ready got %b exp 0", ready); end
        checks++; if (err_nolast !== 1'b1) begin errors++; $display("FAIL nolast_err_held got %b exp 1", err_nolast); end
        checks++; if (data_out !== 64'h0807060504030201) begin errors++; $display("FAIL nolast_data_held got %h exp 0807060504030201", data_out); end
        release_word();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL nolast_rel_ready got %b exp 1", ready); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL nolast_rel_err got %b exp 0", err_nolast); end
        step();
        valid = 1'b0;
        last  = 1'b0;
        checks++; if (data_out !== 64'h0000000000000099) begin errors++; $display("FAIL nolast_next_data got %h exp 99", data_out); end
        checks++; if (word_len !== 4'd1) begin errors++; $display("FAIL nolast_next_len got %0d exp 1", word_len); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL nolast_next_wv got %b exp 1", word_valid); end
        release_word();
    endtask

    task automatic test_hold();
        data  = 8'h5A;
        valid = 1'b1;
        last  = 1'b1;
        step();
        data = 8'hEE;
        last = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_ready_%0d got %b exp 0", i, ready); end
            checks++; if (data_out !== 64'h000000000000005A) begin errors++; $display("FAIL hold_data_%0d got %h exp 5A", i, data_out); end
        end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL hold_wv got %b exp 1", word_valid); end
        release_word();
        valid = 1'b0;
        checks++; if (word_valid !== 1'b0) begin errors++; $display("FAIL hold_rel_wv got %b exp 0", word_valid); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_rel_ready got %b exp 1", ready); end
        step();
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL hold_no_accept got %h exp 0", data_out); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            data  = 8'(8'h11 * (i + 1));
            valid = 1'b1;
            last  = 1'b0;
            step();
        end
        valid = 1'b0;
        checks++; if (data_out !== 64'h0000000000332211) begin errors++; $display("FAIL mid_partial got %h exp 332211", data_out); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (data_out !== 64'd0) begin errors++; $display("FAIL mid_rst_data got %h exp 0", data_out); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b exp 0", ready); end
        checks++; if (word_len !== 4'd0) begin errors++; $display("FAIL mid_rst_len got %0d exp 0", word_len); end
        step();
        reset_n = 1'b1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_idle_ready got %b exp 0", ready); end
        step();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_recv_ready got %b exp 1", ready); end
        data  = 8'hA1;
        valid = 1'b1;
        last  = 1'b1;
        step();
        valid = 1'b0;
        last  = 1'b0;
        checks++; if (data_out !== 64'h00000000000000A1) begin errors++; $display("FAIL mid_new_data got %h exp A1", data_out); end
        checks++; if (word_len !== 4'd1) begin errors++; $display("FAIL mid_new_len got %0d exp 1", word_len); end
        checks++; if (word_valid !== 1'b1) begin errors++; $display("FAIL mid_new_wv got %b exp 1", word_valid); end
        checks++; if (err_nolast !== 1'b0) begin errors++; $display("FAIL mid_new_err got %b exp 0", err_nolast); end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        data    = 8'h00;
        valid   = 1'b0;
        last    = 1'b0;
        re      = 1'b0;
        test_reset();
        test_full_word();
        test_short();
        test_gaps();
        test_missing_last();
        test_hold();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
